icache_refill_sched: RTL

Sequences I$ line refills between the instruction stream buffer and main memory. On each I$ miss it queries the stream buffer first. If the line is present it waits for the line to become ready, or falls back to memory after a timeout. If the line is absent it issues the refill to memory. It returns one line per miss to the I$ and produces prefetcher hit/miss/timeout pulses for the performance counters.

---
 rtl/icache_refill_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/icache_refill_sched.sv
// I$ refill sequencer: stream-buffer lookup first, memory fallback on miss/timeout.
// Ports: clk_i/rst_i; en_i, flush_i; miss_req/addr/gnt; rtrn_*; pf_*; mem_*; perf pulses.
module icache_refill_sched #(
    parameter int PLEN         = 56,
    parameter int LINE_WIDTH   = 128,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  miss_req_i,
    input  logic [PLEN-1:0]       miss_addr_i,
    output logic                  miss_gnt_o,
    output logic                  rtrn_valid_o,
    output logic [LINE_WIDTH-1:0] rtrn_data_o,
    output logic                  rtrn_src_o,
    output logic                  pf_req_o,
    output logic [PLEN-1:0]       pf_addr_o,
    input  logic                  pf_found_i,
    input  logic                  pf_ready_i,
    input  logic [LINE_WIDTH-1:0] pf_data_i,
    output logic                  mem_req_o,
    output logic [PLEN-1:0]       mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    output logic                  pf_hit_o,
    output logic                  pf_miss_o,
    output logic                  pf_timeout_o
);
    localparam int LINE_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, PF_CHECK, PF_WAIT,
        MEM_REQ, MEM_WAIT, DRAIN, RETURN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PLEN-1:0]       addr_q, addr_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic                  src_q, src_d;
    logic                  flush_q, flush_d;
    logic                  wait_last;
    logic                  unused_offset;

    // Offset bits of the miss address never reach the line address.
    assign unused_offset = ^miss_addr_i[LINE_OFFSET-1:0];
    assign wait_last = (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            src_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        src_d   = src_q;
        flush_d = flush_q;
        unique case (state_q)
            IDLE: begin
                if (miss_req_i && !flush_i) begin
                    addr_d  = {miss_addr_i[PLEN-1:LINE_OFFSET],
                               {LINE_OFFSET{1'b0}}};
                    state_d = en_i ? LOOKUP : MEM_REQ;
                end
            end
            LOOKUP: begin
                state_d = flush_i ? IDLE : PF_CHECK;
            end
            PF_CHECK: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (!pf_found_i) begin
                    state_d = MEM_REQ;
                end else if (pf_ready_i) begin
                    data_d  = pf_data_i;
                    src_d   = 1'b1;
                    state_d = RETURN;
                end else begin
                    cnt_d   = '0;
                    state_d = PF_WAIT;
                end
            end
            PF_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (pf_ready_i) begin
                    data_d  = pf_data_i;
                    src_d   = 1'b1;
                    state_d = RETURN;
                end else if (wait_last) begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                // The request stays up until granted; a flush only
                // redirects the granted transfer into DRAIN.
                flush_d = flush_q | flush_i;
                if (mem_gnt_i) begin
                    flush_d = 1'b0;
                    state_d = (flush_q || flush_i) ? DRAIN : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (flush_i) begin
                    state_d = mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem_rvalid_i) begin
                    data_d  = mem_rdata_i;
                    src_d   = 1'b0;
                    state_d = RETURN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        miss_gnt_o   = (state_q == IDLE) && miss_req_i && !flush_i;
        pf_req_o     = (state_q == LOOKUP);
        mem_req_o    = (state_q == MEM_REQ);
        rtrn_valid_o = (state_q == RETURN) && !flush_i;
        pf_addr_o    = addr_q;
        mem_addr_o   = addr_q;
        rtrn_data_o  = data_q;
        rtrn_src_o   = src_q;
        pf_hit_o     = !flush_i &&
                       (((state_q == PF_CHECK) && pf_found_i && pf_ready_i) ||
                        ((state_q == PF_WAIT) && pf_ready_i));
        pf_miss_o    = !flush_i && (state_q == PF_CHECK) && !pf_found_i;
        pf_timeout_o = !flush_i && (state_q == PF_WAIT) &&
                       !pf_ready_i && wait_last;
    end

endmodule
